// File: rtl/tank_motion_if.sv
// rtl/tank_motion_if.sv - tank controller link: frame strobe/command/verdict in, position/heading out
interface tank_motion_if;
  logic       frame_clk;
  logic [2:0] dir_cmd;
  logic       can_move;
  logic [9:0] X_Tank;
  logic [9:0] Y_Tank;
  logic [2:0] tank_dir;
  logic [2:0] facing;
  logic       moving;

  modport master (
    output frame_clk, dir_cmd, can_move,
    input  X_Tank, Y_Tank, tank_dir, facing, moving
  );

  modport slave (
    input  frame_clk, dir_cmd, can_move,
    output X_Tank, Y_Tank, tank_dir, facing, moving
  );
endinterface

// File: rtl/tank_motion.sv
// rtl/tank_motion.sv - per-tank position/heading controller: tick -> check -> update, edge limited
// Optional screen wrap-around instead of edge blocking: define TANK_MOTION_WRAP_EN.
module tank_motion #(
  parameter logic [9:0] X_START   = 10'd32,
  parameter logic [9:0] Y_START   = 10'd32,
  parameter logic [9:0] STEP      = 10'd1,
  parameter logic [9:0] TANK_SIZE = 10'd32,
  parameter logic [9:0] X_MAX     = 10'd639,
  parameter logic [9:0] Y_MAX     = 10'd479,
  parameter int         SPEED_DIV = 4
) (
  input logic        Clk,
  input logic        Reset_n,
  tank_motion_if.slave tm
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] CHECK  = 2'd1;
  localparam logic [1:0] UPDATE = 2'd2;

  localparam logic [2:0] DIR_NONE  = 3'd0;
  localparam logic [2:0] DIR_UP    = 3'd1;
  localparam logic [2:0] DIR_RIGHT = 3'd2;
  localparam logic [2:0] DIR_LEFT  = 3'd3;
  localparam logic [2:0] DIR_DOWN  = 3'd4;

  localparam logic [3:0]  CNT_LAST = 4'(SPEED_DIV - 1);
  localparam logic [10:0] STEP_W   = {1'b0, STEP};
  localparam logic [10:0] SIZE_W   = {1'b0, TANK_SIZE};
  localparam logic [10:0] X_LIM    = {1'b0, X_MAX} + 11'd1;
  localparam logic [10:0] Y_LIM    = {1'b0, Y_MAX} + 11'd1;
`ifdef TANK_MOTION_WRAP_EN
  localparam logic [9:0]  X_WRAP   = X_MAX + 10'd1 - TANK_SIZE;
  localparam logic [9:0]  Y_WRAP   = Y_MAX + 10'd1 - TANK_SIZE;
`endif

  logic [1:0] state;
  logic       frame_prev;
  logic [3:0] spd_cnt;
  logic       eligible;
  logic       go;
  logic [9:0] x_q;
  logic [9:0] y_q;
  logic [2:0] dir_q;
  logic [2:0] facing_q;
  logic       moving_q;
`ifdef TANK_MOTION_WRAP_EN
  logic       in_bounds_q;
`endif

  logic       tick;
  logic [2:0] dir_clean;
  logic       in_bounds;
  logic       go_d;
  logic [9:0] x_nxt;
  logic [9:0] y_nxt;

  assign tm.X_Tank   = x_q;
  assign tm.Y_Tank   = y_q;
  assign tm.tank_dir = dir_q;
  assign tm.facing   = facing_q;
  assign tm.moving   = moving_q;

  assign tick      = tm.frame_clk & ~frame_prev;
  assign dir_clean = (tm.dir_cmd > DIR_DOWN) ? DIR_NONE : tm.dir_cmd;

  // 11-bit arithmetic so edge sums cannot wrap past 1023
  always_comb begin
    in_bounds = 1'b0;
    case (dir_q)
      DIR_UP:    in_bounds = {1'b0, y_q} >= STEP_W;
      DIR_LEFT:  in_bounds = {1'b0, x_q} >= STEP_W;
      DIR_RIGHT: in_bounds = ({1'b0, x_q} + SIZE_W + STEP_W) <= X_LIM;
      DIR_DOWN:  in_bounds = ({1'b0, y_q} + SIZE_W + STEP_W) <= Y_LIM;
      default:   in_bounds = 1'b0;
    endcase
  end

`ifdef TANK_MOTION_WRAP_EN
  assign go_d = eligible & tm.can_move & (dir_q != DIR_NONE);
`else
  assign go_d = eligible & tm.can_move & in_bounds & (dir_q != DIR_NONE);
`endif

  always_comb begin
    x_nxt = x_q;
    y_nxt = y_q;
    case (dir_q)
      DIR_UP:    y_nxt = y_q - STEP;
      DIR_RIGHT: x_nxt = x_q + STEP;
      DIR_LEFT:  x_nxt = x_q - STEP;
      DIR_DOWN:  y_nxt = y_q + STEP;
      default:   ;
    endcase
`ifdef TANK_MOTION_WRAP_EN
    if (!in_bounds_q) begin
      case (dir_q)
        DIR_UP:    y_nxt = Y_WRAP;
        DIR_RIGHT: x_nxt = 10'd0;
        DIR_LEFT:  x_nxt = X_WRAP;
        DIR_DOWN:  y_nxt = 10'd0;
        default:   ;
      endcase
    end
`endif
  end

  // frame_prev resets high so a strobe already asserted at reset release is not a tick
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= IDLE;
      frame_prev <= 1'b1;
      spd_cnt    <= 4'd0;
      eligible   <= 1'b0;
      go         <= 1'b0;
      x_q        <= X_START;
      y_q        <= Y_START;
      dir_q      <= DIR_NONE;
      facing_q   <= DIR_UP;
      moving_q   <= 1'b0;
`ifdef TANK_MOTION_WRAP_EN
      in_bounds_q <= 1'b0;
`endif
    end else begin
      frame_prev <= tm.frame_clk;
      moving_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (tick) begin
            state <= CHECK;
            dir_q <= dir_clean;
            if (dir_clean == DIR_NONE) begin
              spd_cnt  <= 4'd0;
              eligible <= 1'b0;
            end else begin
              facing_q <= dir_clean;
              spd_cnt  <= (spd_cnt == CNT_LAST) ? 4'd0 : spd_cnt + 4'd1;
              eligible <= (spd_cnt == CNT_LAST);
            end
          end
        end
        CHECK: begin
          go    <= go_d;
          state <= UPDATE;
`ifdef TANK_MOTION_WRAP_EN
          in_bounds_q <= in_bounds;
`endif
        end
        UPDATE: begin
          if (go) begin
            x_q      <= x_nxt;
            y_q      <= y_nxt;
            moving_q <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tank_motion.sv
// tb/tb_tank_motion.sv - directed vector bench for tank_motion (SPEED_DIV=1 and SPEED_DIV=4 instances)
module tb_tank_motion;

`ifdef TANK_MOTION_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst1_n;
  logic rst2_n;
  always #5 clk = ~clk;

  tank_motion_if if1();
  tank_motion_if if2();

  tank_motion #(.SPEED_DIV(1)) dut1 (.Clk(clk), .Reset_n(rst1_n), .tm(if1));
  tank_motion #(.SPEED_DIV(4)) dut2 (.Clk(clk), .Reset_n(rst2_n), .tm(if2));

  int n_chk  = 0;
  int n_fail = 0;
  int mv1    = 0;

  always @(negedge clk) if (if1.moving) mv1++;

  typedef struct packed {
    logic [2:0] dir;
    logic       cm;
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] tdir;
    logic [2:0] face;
    logic       mv;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One tick on dut1; command is withdrawn after the tick edge to show it was latched.
  task automatic tick1(input logic [2:0] d, input logic cm, input int ex, input int ey,
                       input int edir, input int eface, input int emv, input bit do_chk);
    int x0;
    int y0;
    @(negedge clk);
    if1.frame_clk = 1'b1;
    if1.dir_cmd   = d;
    if1.can_move  = cm;
    x0 = if1.X_Tank;
    y0 = if1.Y_Tank;
    @(negedge clk);
    if1.dir_cmd = 3'd0;
    @(negedge clk);
    if1.frame_clk = 1'b0;
    if1.can_move  = ~cm;
    if (do_chk) begin
      chk("early_x", if1.X_Tank, x0);
      chk("early_y", if1.Y_Tank, y0);
      chk("early_moving", if1.moving, 0);
    end
    @(negedge clk);
    if (do_chk) begin
      chk("x", if1.X_Tank, ex);
      chk("y", if1.Y_Tank, ey);
      chk("tank_dir", if1.tank_dir, edir);
      chk("facing", if1.facing, eface);
      chk("moving", if1.moving, emv);
    end
    @(negedge clk);
    if (do_chk) chk("moving_pulse_end", if1.moving, 0);
  endtask

  task automatic tick2(input logic [2:0] d, input int ey, input int emv);
    @(negedge clk);
    if2.frame_clk = 1'b1;
    if2.dir_cmd   = d;
    @(negedge clk);
    @(negedge clk);
    if2.frame_clk = 1'b0;
    @(negedge clk);
    chk("div4_y", if2.Y_Tank, ey);
    chk("div4_moving", if2.moving, emv);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[9];
    logic [2:0] d2[15];
    logic       m2[15];
    int ey;
    int mv_before;

    vecs[0] = '{3'd2, 1'b1, 10'd33, 10'd32, 3'd2, 3'd2, 1'b1};
    vecs[1] = '{3'd2, 1'b1, 10'd34, 10'd32, 3'd2, 3'd2, 1'b1};
    vecs[2] = '{3'd2, 1'b1, 10'd35, 10'd32, 3'd2, 3'd2, 1'b1};
    vecs[3] = '{3'd3, 1'b0, 10'd35, 10'd32, 3'd3, 3'd3, 1'b0};
    vecs[4] = '{3'd1, 1'b1, 10'd35, 10'd31, 3'd1, 3'd1, 1'b1};
    vecs[5] = '{3'd4, 1'b1, 10'd35, 10'd32, 3'd4, 3'd4, 1'b1};
    vecs[6] = '{3'd0, 1'b1, 10'd35, 10'd32, 3'd0, 3'd4, 1'b0};
    vecs[7] = '{3'd7, 1'b1, 10'd35, 10'd32, 3'd0, 3'd4, 1'b0};
    vecs[8] = '{3'd3, 1'b1, 10'd34, 10'd32, 3'd3, 3'd3, 1'b1};

    d2 = '{3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4,
           3'd4, 3'd4, 3'd0, 3'd4, 3'd4, 3'd4, 3'd4};
    m2 = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
           1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    // reset with the strobe already high and a movable command present
    rst1_n = 1'b0;
    rst2_n = 1'b0;
    if1.frame_clk = 1'b1; if1.dir_cmd = 3'd2; if1.can_move = 1'b1;
    if2.frame_clk = 1'b1; if2.dir_cmd = 3'd4; if2.can_move = 1'b1;
    repeat (3) @(negedge clk);
    rst1_n = 1'b1;
    rst2_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("reset_x", if1.X_Tank, 32);
    chk("reset_y", if1.Y_Tank, 32);
    chk("reset_facing", if1.facing, 1);
    chk("reset_tank_dir", if1.tank_dir, 0);
    chk("reset_no_moving", mv1, 0);
    if1.frame_clk = 1'b0; if1.dir_cmd = 3'd0;
    if2.frame_clk = 1'b0; if2.dir_cmd = 3'd0;
    @(negedge clk);

    for (int i = 0; i < 9; i++)
      tick1(vecs[i].dir, vecs[i].cm, vecs[i].x, vecs[i].y,
            vecs[i].tdir, vecs[i].face, vecs[i].mv, 1'b1);

    // drive right edge from X=34 to X=607
    for (int i = 0; i < 573; i++) tick1(3'd2, 1'b1, 0, 0, 0, 0, 0, 1'b0);
    chk("approach_x", if1.X_Tank, 607);
    tick1(3'd2, 1'b1, 608, 32, 2, 2, 1, 1'b1);
    tick1(3'd2, 1'b1, WRAP ? 0 : 608, 32, 2, 2, WRAP ? 1 : 0, 1'b1);

    // reset pulse while dut1 is in UPDATE with a committed step pending
    @(negedge clk);
    if1.frame_clk = 1'b1; if1.dir_cmd = 3'd1; if1.can_move = 1'b1;
    @(negedge clk);
    @(negedge clk);
    if1.frame_clk = 1'b0;
    mv_before = mv1;
    rst1_n = 1'b0;
    #1;
    chk("midreset_x", if1.X_Tank, 32);
    chk("midreset_y", if1.Y_Tank, 32);
    chk("midreset_tank_dir", if1.tank_dir, 0);
    chk("midreset_facing", if1.facing, 1);
    chk("midreset_moving", if1.moving, 0);
    @(negedge clk);
    rst1_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("postreset_y", if1.Y_Tank, 32);
    chk("postreset_no_pulse", mv1, mv_before);
    tick1(3'd6, 1'b1, 32, 32, 0, 1, 0, 1'b1);

    // speed divider: every 4th eligible tick moves; a zero command restarts the count
    ey = 32;
    for (int i = 0; i < 15; i++) begin
      ey += int'(m2[i]);
      tick2(d2[i], ey, int'(m2[i]));
    end
    chk("div4_x", if2.X_Tank, 32);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
